// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave WISHBONE arbiter with round-robin grant and a
// no-ack watchdog. One transaction per grant, always followed by an IDLE
// cycle. The grant is registered (one cycle of arbitration latency); the
// slave-side signals and the master acks are combinational from the owner.
//
// Handshake: a master holds stb until it sees ack or err in the same cycle.
// ack_o = s_ack_i & owner stb while BUSY. A master that drops stb
// without ack aborts its transaction, with no ack and no err.
module wb_master_arbiter #(
   parameter int ADR_W       = 8,
   parameter int DAT_W       = 8,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   // master 0 (CPU)
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   output logic [DAT_W-1:0] m0_dat_o,
   input  logic             m0_we_i,
   input  logic             m0_stb_i,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   // master 1 (debug/loader)
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   output logic [DAT_W-1:0] m1_dat_o,
   input  logic             m1_we_i,
   input  logic             m1_stb_i,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   // slave
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   output logic             s_we_o,
   output logic             s_stb_o,
   output logic             s_cyc_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,
   // status
   output logic [1:0]       gnt_o,
   output logic             timeout_o,
   output logic             o_dbg_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam bit WD_EN = (TIMEOUT_CYC != 0);
   // Counter value seen on the last allowed BUSY cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   state_t           r_state;
   logic             r_owner;   // 0 = m0, 1 = m1
   logic             r_last;    // master that owned the most recent grant
   logic [CNT_W-1:0] r_cnt;

   state_t           w_state_nxt;
   logic             w_owner_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic             w_busy;
   logic             w_own_stb;
   logic             w_ack;
   logic             w_expire;

   assign w_busy    = (r_state == ST_BUSY);
   assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
   assign w_ack     = w_busy & s_ack_i & w_own_stb;
   // Ack on the final cycle wins over expiry.
   assign w_expire  = WD_EN & w_busy & w_own_stb & ~s_ack_i & (r_cnt == CNT_LAST);

   // Read data is broadcast; each master qualifies it with its own ack.
   assign m0_dat_o    = s_dat_i;
   assign m1_dat_o    = s_dat_i;
   assign o_dbg_state = r_state;

   // State, owner, round-robin pointer and watchdog counter registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state arbitration and owner-muxed bus outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_cnt_nxt   = '0;
      s_adr_o     = '0;
      s_dat_o     = '0;
      s_we_o      = 1'b0;
      s_stb_o     = 1'b0;
      s_cyc_o     = 1'b0;
      gnt_o       = 2'b00;
      m0_ack_o    = 1'b0;
      m1_ack_o    = 1'b0;
      m0_err_o    = 1'b0;
      m1_err_o    = 1'b0;
      timeout_o   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_stb_i | m1_stb_i) begin
               w_state_nxt = ST_BUSY;
               if (m0_stb_i & m1_stb_i)
                  w_owner_nxt = ~r_last;
               else
                  w_owner_nxt = m1_stb_i;
            end
         end
         ST_BUSY: begin
            s_cyc_o   = 1'b1;
            gnt_o     = r_owner ? 2'b10 : 2'b01;
            s_adr_o   = r_owner ? m1_adr_i : m0_adr_i;
            s_dat_o   = r_owner ? m1_dat_i : m0_dat_i;
            s_we_o    = r_owner ? m1_we_i  : m0_we_i;
            s_stb_o   = w_own_stb & ~w_expire;
            m0_ack_o  = w_ack & ~r_owner;
            m1_ack_o  = w_ack &  r_owner;
            m0_err_o  = w_expire & ~r_owner;
            m1_err_o  = w_expire &  r_owner;
            timeout_o = w_expire;
            if (w_ack | w_expire | ~w_own_stb) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_owner;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (TIMEOUT_CYC = 4). A table of
// per-cycle vectors drives both masters and the slave, and the packed
// output snapshot is compared against hand-computed values. Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// Master write data is fixed: m0 drives 0x11, m1 drives 0x33.
module tb_wb_master_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
   logic       m0_we, m0_stb, m0_ack, m0_err, m1_we, m1_stb, m1_ack, m1_err;
   logic [7:0] s_adr, s_wdat, s_rdat;
   logic       s_we, s_stb, s_cyc, s_ack;
   logic [1:0] gnt;
   logic       tmo, dbg_state;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_master_arbiter #(
      .ADR_W(8), .DAT_W(8), .TIMEOUT_CYC(4), .CNT_W(8)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
      .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
      .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
      .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .gnt_o(gnt), .timeout_o(tmo), .o_dbg_state(dbg_state)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst;
      logic [1:0] stb;   // {m1, m0}
      logic [1:0] we;    // {m1, m0}
      logic [7:0] a0;
      logic [7:0] a1;
      logic       sack;
      logic [7:0] sdat;
   } vec_t;

   vec_t        vec_q[$];
   logic [41:0] exp_q[$];

   localparam logic [33:0] IDLE_E = '0;

   // Expected BUSY snapshot: {gnt, s_stb, s_cyc=1, s_we, s_adr, s_dat, ack, err, timeout}
   function automatic logic [33:0] busy(input logic [1:0] g, input logic st, input logic we,
                                        input logic [7:0] adr, input logic [7:0] wd,
                                        input logic [1:0] ack, input logic [1:0] err,
                                        input logic to);
      return {g, st, 1'b1, we, adr, wd, ack, err, to};
   endfunction

   task automatic add(input logic r, input logic [1:0] stb, input logic [1:0] we,
                      input logic [7:0] a0, input logic [7:0] a1, input logic sack,
                      input logic [7:0] sdat, input logic [33:0] e);
      vec_t v;
      v.rst = r; v.stb = stb; v.we = we; v.a0 = a0; v.a1 = a1; v.sack = sack; v.sdat = sdat;
      vec_q.push_back(v);
      exp_q.push_back({e, sdat, sdat});   // read data broadcast to both masters
   endtask

   function automatic logic [41:0] snapshot();
      return {gnt, s_stb, s_cyc, s_we, s_adr, s_wdat, m1_ack, m0_ack, m1_err, m0_err, tmo,
              m0_rdat, m1_rdat};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fill_table();
      // reset state
      add(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, IDLE_E);
      // m0 reads 0x20, ack with 0x5A on the second BUSY cycle
      add(0, 2'b01, 2'b00, 8'h20, 8'h00, 0, 8'h00, IDLE_E);
      add(0, 2'b01, 2'b00, 8'h20, 8'h00, 0, 8'h00, busy(2'b01, 1, 0, 8'h20, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b01, 2'b00, 8'h20, 8'h00, 1, 8'h5A, busy(2'b01, 1, 0, 8'h20, 8'h11, 2'b01, 2'b00, 0));
      add(0, 2'b00, 2'b00, 8'h20, 8'h00, 0, 8'h00, IDLE_E);
      // m1 writes 0x33 to 0x05, three wait cycles; ack coincides with watchdog limit
      add(0, 2'b10, 2'b10, 8'h00, 8'h05, 0, 8'h00, IDLE_E);
      add(0, 2'b10, 2'b10, 8'h00, 8'h05, 0, 8'h00, busy(2'b10, 1, 1, 8'h05, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b10, 2'b10, 8'h00, 8'h05, 0, 8'h00, busy(2'b10, 1, 1, 8'h05, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b10, 2'b10, 8'h00, 8'h05, 0, 8'h00, busy(2'b10, 1, 1, 8'h05, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b10, 2'b10, 8'h00, 8'h05, 1, 8'hAA, busy(2'b10, 1, 1, 8'h05, 8'h33, 2'b10, 2'b00, 0));
      add(0, 2'b00, 2'b00, 8'h00, 8'h05, 0, 8'h00, IDLE_E);
      // m0 times out while m1 waits; m1 then granted; s_ack_i in IDLE ignored
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 0, 8'h00, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 0, 0, 8'h40, 8'h11, 2'b00, 2'b01, 1));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h3C, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b10, 1, 0, 8'h77, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h99, busy(2'b10, 1, 0, 8'h77, 8'h33, 2'b10, 2'b00, 0));
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 0, 8'h00, IDLE_E);
      // m0: ack lands on the expiry cycle -> ack, no err, no timeout
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b01, 2'b00, 8'h40, 8'h77, 1, 8'hC3, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b01, 2'b00, 0));
      add(0, 2'b00, 2'b00, 8'h40, 8'h77, 0, 8'h00, IDLE_E);
      // m1 aborts by dropping stb (slave ack that cycle must not pass); pointer still advances
      add(0, 2'b10, 2'b10, 8'h40, 8'h05, 0, 8'h00, IDLE_E);
      add(0, 2'b10, 2'b10, 8'h40, 8'h05, 0, 8'h00, busy(2'b10, 1, 1, 8'h05, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b00, 2'b10, 8'h40, 8'h05, 1, 8'h66, busy(2'b10, 0, 1, 8'h05, 8'h33, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b00, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h12, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b01, 2'b00, 0));
      // reset, then both masters request continuously with an always-acking slave
      add(1, 2'b11, 2'b00, 8'h40, 8'h77, 0, 8'h00, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h00, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h01, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b01, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h02, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h03, busy(2'b10, 1, 0, 8'h77, 8'h33, 2'b10, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h04, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h05, busy(2'b01, 1, 0, 8'h40, 8'h11, 2'b01, 2'b00, 0));
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h06, IDLE_E);
      add(0, 2'b11, 2'b00, 8'h40, 8'h77, 1, 8'h07, busy(2'b10, 1, 0, 8'h77, 8'h33, 2'b10, 2'b00, 0));
   endtask

   // ---------------- driver ----------------
   task automatic drive(input vec_t v);
      rst    = v.rst;
      m0_stb = v.stb[0]; m1_stb = v.stb[1];
      m0_we  = v.we[0];  m1_we  = v.we[1];
      m0_adr = v.a0;     m1_adr = v.a1;
      s_ack  = v.sack;   s_rdat = v.sdat;
   endtask

   // ---------------- test ----------------
   initial begin
      rst = 1'b1;
      m0_adr = '0; m1_adr = '0; m0_we = 1'b0; m1_we = 1'b0;
      m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; s_rdat = '0;
      m0_wdat = 8'h11; m1_wdat = 8'h33;
      fill_table();
      repeat (2) @(posedge clk);

      for (int i = 0; i < vec_q.size(); i++) begin
         logic [41:0] e;
         @(posedge clk); #1;
         drive(vec_q[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d", i), 64'(snapshot()), 64'(e));
      end

      // Asynchronous reset in the middle of a BUSY cycle
      @(posedge clk); #1;
      rst = 1'b0; m0_stb = 1'b1; m1_stb = 1'b0; m0_adr = 8'h40; s_ack = 1'b0;
      @(posedge clk); #1;
      chk("busy_before_reset", 64'({gnt, s_cyc, dbg_state}), 64'({2'b01, 1'b1, 1'b1}));
      #2;
      rst = 1'b1; s_ack = 1'b1;
      #1;
      chk("async_reset_outputs", 64'({gnt, s_stb, s_cyc, m0_ack, m1_ack, m0_err, m1_err, tmo, dbg_state}),
          64'(0));
      @(posedge clk); #1;
      rst = 1'b0; s_ack = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1;
      @(negedge clk);
      chk("idle_after_release", 64'({gnt, s_cyc}), 64'(0));
      @(posedge clk); #1;
      chk("first_grant_after_reset", 64'({gnt, s_stb, s_adr}), 64'({2'b01, 1'b1, 8'h40}));
      s_ack = 1'b1; s_rdat = 8'hE7;
      @(negedge clk);
      chk("ack_after_reset", 64'({m0_ack, m1_ack, m0_err, m0_rdat}), 64'({1'b1, 1'b0, 1'b0, 8'hE7}));
      @(posedge clk); #1;
      m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
